// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the RISC-V data-memory responder.
//   dmem_size_e    : access size encoding on mem_size (11 is illegal)
//   dmem_state_e   : responder FSM states
//   dmem_req_t     : request fields latched on the accepting edge
//   DMEM_MMIO_ADDR : display register address (only decoded when the
//                    DMEM_MMIO_EN macro is defined)
//   dmem_bad_access: size/alignment/conflict check for a latched request
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } dmem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    typedef struct packed {
        logic        wr;     // store (also set for read+write conflicts)
        logic        both;   // mem_read and mem_write were both high
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    localparam logic [31:0] DMEM_MMIO_ADDR = 32'hFFFF_FFF0;

    // True when the request can never be served regardless of address range:
    // read/write conflict, illegal size, or a misaligned half/word.
    function automatic logic dmem_bad_access(input logic       both,
                                             input logic [1:0] size,
                                             input logic [1:0] lane);
        logic bad;
        bad = both;
        case (size)
            SZ_B:    ;
            SZ_H:    bad = bad | lane[0];
            SZ_W:    bad = bad | (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for loads and stores.
//   i_word     : current 32-bit contents of the addressed word
//   i_lane     : addr[1:0] of the access
//   i_size     : access size (SZ_B / SZ_H / SZ_W)
//   i_unsigned : zero-extend sub-word loads when 1
//   i_wdata    : right-justified store data
//   o_load     : right-justified, sign/zero-extended load value
//   o_store    : i_word with only the addressed lanes replaced by i_wdata
// Word accesses pass straight through (mem_unsigned has no effect).
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load  = i_word;
        o_store = i_wdata;
        case (i_size)
            SZ_B: begin
                o_load  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_store = i_word;
                o_store[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_H: begin
                o_load  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_store = i_word;
                o_store[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_dmem_responder
// Memory end of the RISC-V core's data interface. A request is latched on the
// first edge it is seen in IDLE, held for LATENCY cycles (WAIT), and answered
// with a one-cycle mem_ready pulse (RESP). Stores commit on the edge leaving
// RESP, so a load accepted afterwards always sees the new data.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two)
//   BASE_ADDR   : byte address of word 0 (4-aligned)
//   LATENCY     : accepting edge to mem_ready, 1..4 cycles
//
// Ports
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous active-low reset (memory array not cleared)
//   i_mem_read     : load request, held until mem_ready
//   i_mem_write    : store request, held until mem_ready
//   i_mem_size     : 00 byte, 01 half, 10 word, 11 illegal
//   i_mem_unsigned : zero-extend sub-word loads
//   i_data_addr    : byte address
//   i_write_data   : right-justified store data
//   o_read_data    : load result while mem_ready, else 0
//   o_mem_ready    : one-cycle completion pulse
//   o_mem_err      : request rejected (valid with mem_ready)
//   o_display_data : MMIO display register
//
// Build option
//   DMEM_MMIO_EN : when defined, DMEM_MMIO_ADDR is a word-only display
//                  register; otherwise that address is plain out-of-range
//                  and o_display_data is tied to 0.
// -----------------------------------------------------------------------------
module riscv_dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_mem_ready,
    output logic        o_mem_err,
    output logic [31:0] o_display_data
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    // WAIT spends WAIT_INIT+1 cycles, so RESP lands LATENCY edges after accept.
    localparam logic [1:0]  WAIT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    dmem_state_e r_state;
    logic [1:0]  r_cnt;
    dmem_req_t   r_req;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_is_mmio;
    logic [31:0]   w_mmio_word;
    logic          w_err;
    logic          w_commit;
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic [31:0]   w_store;

    assign w_accept   = (r_state == IDLE) && (i_mem_read || i_mem_write);

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail
    // the range compare.
    assign w_off      = r_req.addr - BASE_ADDR;
    assign w_in_range = {1'b0, w_off} < MEM_BYTES;
    assign w_idx      = w_off[AW+1:2];

`ifdef DMEM_MMIO_EN
    logic [31:0] r_display;

    assign w_is_mmio   = (r_req.addr == DMEM_MMIO_ADDR);
    assign w_mmio_word = r_display;
`else
    assign w_is_mmio   = 1'b0;
    assign w_mmio_word = 32'd0;
`endif

    // The MMIO register is word-only and takes priority over the array
    // decode, even if BASE_ADDR places the array under it.
    assign w_err = dmem_bad_access(r_req.both, r_req.size, r_req.addr[1:0])
                 | (w_is_mmio ? (r_req.size != SZ_W) : !w_in_range);

    assign w_word   = w_is_mmio ? w_mmio_word : r_mem[w_idx];
    assign w_commit = (r_state == RESP) && r_req.wr && !w_err;

    dmem_lane_align u_align (
        .i_word     (w_word),
        .i_lane     (r_req.addr[1:0]),
        .i_size     (r_req.size),
        .i_unsigned (r_req.uns),
        .i_wdata    (r_req.wdata),
        .o_load     (w_load),
        .o_store    (w_store)
    );

    // Request FSM. Inputs are only looked at in IDLE; WAIT and RESP work
    // from the latched copy even if the core drops or changes its request.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_req   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req <= '{wr:    i_mem_write,
                                   both:  i_mem_read & i_mem_write,
                                   size:  i_mem_size,
                                   uns:   i_mem_unsigned,
                                   addr:  i_data_addr,
                                   wdata: i_write_data};
                        r_cnt   <= WAIT_INIT;
                        r_state <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array has no reset. The i_reset term keeps a reset that overlaps the
    // RESP edge from committing the aborted store.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_commit && !w_is_mmio) begin
            r_mem[w_idx] <= w_store;
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_display <= 32'd0;
        end else if (w_commit && w_is_mmio) begin
            r_display <= w_store;
        end
    end

    assign o_display_data = r_display;
`else
    assign o_display_data = 32'd0;
`endif

    assign o_mem_ready = (r_state == RESP);
    assign o_mem_err   = o_mem_ready && w_err;
    assign o_read_data = (o_mem_ready && !w_err && !r_req.wr) ? w_load : 32'd0;

endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
- Synthesizable data-memory responder for the single-cycle/multi-cycle RISC-V core: the memory end of the core's data-memory request interface (mem_read, mem_write, data_addr, write_data, read_data).
- Adds a configurable wait-state, a mem_ready completion pulse, sized/aligned loads and stores, and error flagging.
- Sits beside the core in the top level; the verification environment drives the same signals for comparison against the scoreboard.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; 4-aligned.
- LATENCY, 1: cycles from request acceptance to the mem_ready pulse; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- mem_read  in  1  load request; held by the core until mem_ready.
- mem_write  in  1  store request; held by the core until mem_ready.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- mem_unsigned  in  1  zero-extend loads (LBU/LHU) when 1.
- data_addr  in  32  byte address (the core's ALU result).
- write_data  in  32  store data, right-justified.
- read_data  out  32  load result; valid only while mem_ready=1, otherwise 0.
- mem_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  valid with mem_ready: request was rejected.
- display_data  out  32  MMIO display register.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; read_data=0, mem_ready=0, mem_err=0, display_data=0; latched request cleared.
  - Memory array is not cleared.
  - Reset asserted mid-transaction aborts it: no write commits and no mem_ready is issued.
- IDLE:
  - On the first edge where mem_read|mem_write=1, latch addr, size, unsigned, wdata and op.
  - Go to WAIT if LATENCY>1, else go to RESP.
- WAIT:
  - Down-counter loaded with LATENCY-2; decrement each cycle; at 0 go to RESP.
  - Inputs are ignored; the latched copy is used even if the core changes or drops its request.
- RESP (exactly one cycle):
  - mem_ready=1 and read_data/mem_err are driven combinationally from the latched request.
  - A store commits to the array on the edge leaving RESP.
  - Next state is always IDLE. A request still high in IDLE is treated as a new request, so back-to-back requests complete every LATENCY+1 cycles.
- Total latency: mem_ready is high LATENCY cycles after the accepting edge.
- Error conditions (mem_err=1, no write, read_data=0):
  - mem_read and mem_write both 1 at acceptance;
  - mem_size=11;
  - half at addr[0]=1;
  - word at addr[1:0]!=0;
  - (data_addr-BASE_ADDR) >= DEPTH_WORDS*4, unless it is the MMIO address (see Optional Feature).
- Loads:
  - Word index = (addr-BASE_ADDR)>>2.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Result is right-justified and sign- or zero-extended per mem_unsigned; a word load ignores mem_unsigned.
- Stores:
  - Only the addressed byte or half lanes are modified, taken from the low bits of write_data.
  - Other lanes are preserved.
- Read-after-write: a load accepted after a store's RESP sees the new data. The commit edge precedes the next acceptance edge, so no bypass is needed.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - A word store to DMEM_MMIO_ADDR (32'hFFFF_FFF0) updates display_data on the edge leaving RESP.
  - A word load from that address returns display_data.
  - Byte or half access to that address sets mem_err.
- Undefined:
  - That address is handled as ordinary out-of-range (mem_err=1).
  - display_data is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - size enum (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10);
  - state enum (IDLE, WAIT, RESP);
  - DMEM_MMIO_ADDR constant;
  - a function computing the legality/misalignment check.
- One sub-module, dmem_lane_align (combinational): given a word, addr[1:0], size and unsigned, produces the extended load value; given write_data, produces the merged store word.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> each op gives mem_ready 1 cycle after acceptance; load returns 0xDEADBEEF, mem_err=0.
- Bytes/halves: after the word 0xDEADBEEF @0x10:
  - LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
  - SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF.
- Errors:
  - LW @0x12 -> mem_err=1, read_data=0.
  - SW @0x1000 (DEPTH_WORDS=1024) -> mem_err=1; a later LW @0x0 is unchanged.
  - mem_read=mem_write=1 -> mem_err=1, no write.
- LATENCY=3, core drops mem_read one cycle after acceptance -> mem_ready still pulses 3 cycles after acceptance with the correct data. Held requests complete every 4 cycles.
- reset=0 asserted in WAIT during SW 0x1234 @0x20 -> no mem_ready; LW @0x20 after reset returns the prior contents.
- DMEM_MMIO_EN: SW 0x000000A5 @0xFFFFFFF0 -> display_data=0xA5 the cycle after RESP; without the macro -> mem_err=1 and display_data stays 0.
